exec_unit_mc: RTL and testbench
===============================

# exec_unit_mc

Parametrised multi-cycle execute stage for the 5-stage pipelined RISC core, replacing the purely combinational execute path. It keeps the operand-forwarding muxes, immediate select and destination select. It registers its results and adds iterative multiply, unsigned divide and unsigned remainder, with a valid/ready handshake and a busy output that the hazard unit uses to stall IF/ID. Single-cycle ops complete in 1 cycle; MUL/DIVU/REMU complete in XLEN+1 cycles.

## Interface
- XLEN, 32, datapath width (≥8)
- REG_AW, 5, register-address width
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ID/EX presents an instruction
- in_ready  out  1  unit can accept (high only in IDLE)
- alu_op  in  4  operation code (exec_pkg)
- alu_src  in  1  1: B = imm; 0: B = forwarded rt
- reg_dst  in  1  1: dest = rd_addr; 0: dest = rt_addr
- rs_data, rt_data  in  XLEN  register-file read data
- imm  in  XLEN  sign-extended immediate
- rd_addr, rt_addr  in  REG_AW  candidate destinations
- fwd_rs, fwd_rt  in  2  00 regfile, 01 fwd_mem_data, 10 fwd_wb_data, 11 treated as 00
- fwd_mem_data, fwd_wb_data  in  XLEN  EX/MEM result, WB write data
- flush  in  1  kill in-flight op (branch/exception)
- out_valid  out  1  one-cycle pulse: result registers valid
- out_result  out  XLEN  ALU result
- out_store_data  out  XLEN  forwarded rt value (for SW)
- out_dest  out  REG_AW  selected destination
- out_zero  out  1  out_result == 0
- out_multicycle  out  1  result came from MUL/DIVU/REMU
- busy  out  1  state != IDLE (combinational)

## Operation
- Operand A = fwd_rs mux; W = fwd_rt mux; B = alu_src ? imm : W. All sampled only on the accept edge (in_valid && in_ready && !flush).
- Ops:
  - 0000 NOR
  - 0001 SLT (signed, result 1/0)
  - 0010 ADD
  - 0110 SUB
  - 0011 AND
  - 0111 OR
  - 0100 MUL (low XLEN bits of A×B, shift-add)
  - 1000 DIVU quotient
  - 1001 REMU (restoring)
  - Any other code: result 0, single-cycle.
- ADD/SUB wrap modulo 2^XLEN; no overflow flag.
- Divide by zero: quotient all-ones, remainder = A.
- FSM states IDLE, MUL, DIV.
  - IDLE + accept of a single-cycle op: result/dest/store_data/zero registered; out_valid=1 next cycle; stay IDLE.
  - IDLE + accept of MUL → MUL; of DIVU/REMU → DIV. Operands, dest and W are latched; cnt ← XLEN-1.
  - MUL/DIV: one iteration per cycle. At cnt==0 the final step writes the outputs, out_valid=1 and out_multicycle=1, state → IDLE; else cnt decrements.
- out_valid is a single-cycle pulse; there is no downstream backpressure.
- flush: from any state → IDLE next edge, in-flight result discarded, out_valid=0. Flush with in_valid in the same cycle: not accepted.
- rst: state IDLE, cnt 0. All outputs 0 (out_valid, out_result, out_store_data, out_dest, out_zero, out_multicycle), except out_zero and in_ready. After reset: out_zero = 1 (result 0), in_ready = 1, busy = 0.

## Timing
- Single-cycle op accepted at edge k: outputs valid cycle k+1.
- Multi-cycle op accepted at edge k:
  - in_ready=0 and busy=1 for cycles k+1 … k+XLEN.
  - out_valid in cycle k+XLEN+1, when in_ready is already 1, so a back-to-back accept is allowed.
- Registered outputs hold their value between pulses; only out_valid drops.
- in_ready depends only on state, never combinationally on in_valid.
- Reset or flush asserted mid-MUL/DIV takes effect at the next edge; no partial result is ever pulsed.

## Structure
- Package exec_pkg: alu_op localparams, fwd-select codes, FSM state enum, XLEN-independent constants.
- Sub-module iter_muldiv handles the iterative work.
  - Ports: start, is_div, a, b, flush, done, prod_lo, quot, rem.
  - One bit per cycle, XLEN cycles.
- The top level holds the forwarding muxes, single-cycle ALU, FSM and output registers.

## Test plan
- ADD with fwd_rs=01 (fwd_mem_data=5), rt_data=3, alu_src=0 → next cycle out_result=8, out_zero=0, out_dest=rt_addr (reg_dst=0).
- SLT with A=32'hFFFF_FFFF, B=1 → 1. SUB 9−9 → 0, out_zero=1. Op 1111 → 0.
- MUL 7×6 → in_ready low 32 cycles, out_valid at cycle 33 with 42 and out_multicycle=1. Then 32'h1_0000×32'h1_0000 → 0 (wrap).
- DIVU 100/7 → 14; REMU 100/7 → 2. DIVU 5/0 → 32'hFFFF_FFFF; REMU 5/0 → 5.
- flush asserted 10 cycles into MUL → IDLE next cycle, no out_valid pulse, in_ready=1. Flush plus in_valid in the same cycle → no acceptance.
- Back-to-back: MUL accepted; ADD presented during busy is held until in_ready; ADD accepted in the MUL out_valid cycle → its out_valid follows one cycle later. rst mid-DIV → all outputs 0 next cycle.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared opcodes, forwarding-select codes and FSM states for the multi-cycle execute stage.
package exec_pkg;

    localparam logic [3:0] OP_NOR  = 4'b0000;
    localparam logic [3:0] OP_SLT  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_MUL  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_DIVU = 4'b1000;
    localparam logic [3:0] OP_REMU = 4'b1001;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative shift-add multiplier and restoring unsigned divider, one bit per cycle over XLEN cycles.
module iter_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_div,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            done,
    output logic [XLEN-1:0] prod_lo,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem
);

    localparam int CW = $clog2(XLEN);

    logic            r_busy;
    logic            r_is_div;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_divisor;

    logic [XLEN-1:0] w_acc_next;
    logic [XLEN:0]   w_trial;
    logic [XLEN:0]   w_diff;
    logic            w_qbit;
    logic [XLEN-1:0] w_rem_next;
    logic [XLEN-1:0] w_quot_next;

    // Outputs are the post-step values so the final step can be captured on the done edge.
    always_comb begin
        w_acc_next  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
        w_trial     = {r_rem, r_quot[XLEN-1]};
        w_diff      = w_trial - {1'b0, r_divisor};
        w_qbit      = ~w_diff[XLEN];
        w_rem_next  = w_qbit ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0];
        w_quot_next = {r_quot[XLEN-2:0], w_qbit};
    end

    assign done    = r_busy && (r_cnt == '0);
    assign prod_lo = w_acc_next;
    assign quot    = w_quot_next;
    assign rem     = w_rem_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_is_div  <= 1'b0;
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
        end else if (flush) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (start && !r_busy) begin
            r_busy    <= 1'b1;
            r_is_div  <= is_div;
            r_cnt     <= CW'(XLEN - 1);
            r_mcand   <= a;
            r_mplier  <= b;
            r_acc     <= '0;
            r_rem     <= '0;
            r_quot    <= a;
            r_divisor <= b;
        end else if (r_busy) begin
            if (r_is_div) begin
                r_rem  <= w_rem_next;
                r_quot <= w_quot_next;
            end else begin
                r_acc    <= w_acc_next;
                r_mcand  <= {r_mcand[XLEN-2:0], 1'b0};
                r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
            end
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/exec_unit_mc.sv
// Multi-cycle execute stage: forwarding muxes, single-cycle ALU, registered results and
// an iterative MUL/DIVU/REMU path behind a valid/ready handshake.
module exec_unit_mc
    import exec_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_op,
    input  logic              alu_src,
    input  logic              reg_dst,
    input  logic [XLEN-1:0]   rs_data,
    input  logic [XLEN-1:0]   rt_data,
    input  logic [XLEN-1:0]   imm,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic [1:0]        fwd_rs,
    input  logic [1:0]        fwd_rt,
    input  logic [XLEN-1:0]   fwd_mem_data,
    input  logic [XLEN-1:0]   fwd_wb_data,
    input  logic              flush,
    output logic              out_valid,
    output logic [XLEN-1:0]   out_result,
    output logic [XLEN-1:0]   out_store_data,
    output logic [REG_AW-1:0] out_dest,
    output logic              out_zero,
    output logic              out_multicycle,
    output logic              busy
);

    state_t            r_state;
    state_t            w_state_next;
    logic [REG_AW-1:0] r_dest_lat;
    logic [XLEN-1:0]   r_w_lat;
    logic              r_is_rem;
    logic              r_out_valid;
    logic [XLEN-1:0]   r_out_result;
    logic [XLEN-1:0]   r_out_store_data;
    logic [REG_AW-1:0] r_out_dest;
    logic              r_out_zero;
    logic              r_out_multicycle;

    logic [XLEN-1:0]   w_a;
    logic [XLEN-1:0]   w_w;
    logic [XLEN-1:0]   w_b;
    logic [XLEN-1:0]   w_alu;
    logic [REG_AW-1:0] w_dest;
    logic              w_accept;
    logic              w_start;
    logic              w_done;
    logic [XLEN-1:0]   w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_mc_result;

    assign in_ready = (r_state == ST_IDLE);
    assign busy     = (r_state != ST_IDLE);
    assign w_accept = in_valid && in_ready && !flush;
    assign w_start  = w_accept && is_multicycle(alu_op);
    assign w_dest   = reg_dst ? rd_addr : rt_addr;

    always_comb begin
        case (fwd_rs)
            FWD_MEM: w_a = fwd_mem_data;
            FWD_WB:  w_a = fwd_wb_data;
            default: w_a = rs_data;
        endcase
        case (fwd_rt)
            FWD_MEM: w_w = fwd_mem_data;
            FWD_WB:  w_w = fwd_wb_data;
            default: w_w = rt_data;
        endcase
        w_b = alu_src ? imm : w_w;
    end

    always_comb begin
        case (alu_op)
            OP_NOR:  w_alu = ~(w_a | w_b);
            OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            OP_ADD:  w_alu = w_a + w_b;
            OP_SUB:  w_alu = w_a - w_b;
            OP_AND:  w_alu = w_a & w_b;
            OP_OR:   w_alu = w_a | w_b;
            default: w_alu = '0;
        endcase
    end

    iter_muldiv #(.XLEN(XLEN)) u_iter (
        .clk     (clk),
        .rst     (rst),
        .start   (w_start),
        .is_div  (alu_op != OP_MUL),
        .a       (w_a),
        .b       (w_b),
        .flush   (flush),
        .done    (w_done),
        .prod_lo (w_prod),
        .quot    (w_quot),
        .rem     (w_rem)
    );

    assign w_mc_result = (r_state == ST_MUL) ? w_prod : (r_is_rem ? w_rem : w_quot);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && alu_op == OP_MUL) begin
                        w_state_next = ST_MUL;
                    end else if (w_accept && (alu_op == OP_DIVU || alu_op == OP_REMU)) begin
                        w_state_next = ST_DIV;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (w_done) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Flush suppresses both a new single-cycle result and a finishing iterative one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dest_lat       <= '0;
            r_w_lat          <= '0;
            r_is_rem         <= 1'b0;
            r_out_valid      <= 1'b0;
            r_out_result     <= '0;
            r_out_store_data <= '0;
            r_out_dest       <= '0;
            r_out_zero       <= 1'b1;
            r_out_multicycle <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_start) begin
                r_dest_lat <= w_dest;
                r_w_lat    <= w_w;
                r_is_rem   <= (alu_op == OP_REMU);
            end
            if (!flush) begin
                if (w_accept && !w_start) begin
                    r_out_valid      <= 1'b1;
                    r_out_result     <= w_alu;
                    r_out_store_data <= w_w;
                    r_out_dest       <= w_dest;
                    r_out_zero       <= (w_alu == '0);
                    r_out_multicycle <= 1'b0;
                end else if (busy && w_done) begin
                    r_out_valid      <= 1'b1;
                    r_out_result     <= w_mc_result;
                    r_out_store_data <= r_w_lat;
                    r_out_dest       <= r_dest_lat;
                    r_out_zero       <= (w_mc_result == '0);
                    r_out_multicycle <= 1'b1;
                end
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign out_result     = r_out_result;
    assign out_store_data = r_out_store_data;
    assign out_dest       = r_out_dest;
    assign out_zero       = r_out_zero;
    assign out_multicycle = r_out_multicycle;

endmodule

// File: tb/tb_exec_unit_mc.sv
// Self-checking bench for exec_unit_mc: directed cases plus randomized ops against an arithmetic model.
module tb_exec_unit_mc;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        alu_op;
    logic              alu_src;
    logic              reg_dst;
    logic [XLEN-1:0]   rs_data;
    logic [XLEN-1:0]   rt_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd_addr;
    logic [REG_AW-1:0] rt_addr;
    logic [1:0]        fwd_rs;
    logic [1:0]        fwd_rt;
    logic [XLEN-1:0]   fwd_mem_data;
    logic [XLEN-1:0]   fwd_wb_data;
    logic              flush;
    logic              out_valid;
    logic [XLEN-1:0]   out_result;
    logic [XLEN-1:0]   out_store_data;
    logic [REG_AW-1:0] out_dest;
    logic              out_zero;
    logic              out_multicycle;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exec_unit_mc #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
        .rd_addr(rd_addr), .rt_addr(rt_addr), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
        .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data), .flush(flush),
        .out_valid(out_valid), .out_result(out_result), .out_store_data(out_store_data),
        .out_dest(out_dest), .out_zero(out_zero), .out_multicycle(out_multicycle), .busy(busy)
    );

    // Reference model: operand selection and arithmetic straight from the operation table.
    function automatic logic [XLEN-1:0] m_sel(input logic [1:0] f, input logic [XLEN-1:0] rf,
                                              input logic [XLEN-1:0] mem, input logic [XLEN-1:0] wb);
        if (f == 2'b01) return mem;
        if (f == 2'b10) return wb;
        return rf;
    endfunction

    function automatic logic [XLEN-1:0] m_alu(input logic [3:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        case (op)
            4'b0000: return ~(a | b);
            4'b0001: return ($signed(a) < $signed(b)) ? 1 : 0;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0011: return a & b;
            4'b0111: return a | b;
            4'b0100: return a * b;
            4'b1000: return (b == 0) ? {XLEN{1'b1}} : a / b;
            4'b1001: return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    function automatic bit m_multi(input logic [3:0] op);
        return op == 4'b0100 || op == 4'b1000 || op == 4'b1001;
    endfunction

    task automatic set_plain(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        alu_op = op; rs_data = a; rt_data = b; alu_src = 1'b0; reg_dst = 1'b1;
        fwd_rs = 2'b00; fwd_rt = 2'b00; rd_addr = 5'd7; rt_addr = 5'd9;
    endtask

    // Presents the current inputs, waits through the accept edge and returns cycles until out_valid.
    task automatic issue(output int lat, output int busy_cycles);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1; busy_cycles = 0;
        while (!out_valid && lat < 4 * XLEN) begin
            if (busy === 1'b1 && in_ready === 1'b0) busy_cycles++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
        set_plain(4'b0010, '0, '0); imm = '0; fwd_mem_data = '0; fwd_wb_data = '0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        checks++; if ({out_valid, out_multicycle, busy} !== 3'b000) begin errors++;
            $display("FAIL reset_flags valid/mc/busy got=%b exp=000", {out_valid, out_multicycle, busy}); end
        checks++; if ({out_result, out_store_data, out_dest} !== '0) begin errors++;
            $display("FAIL reset_data got=%h/%h/%h exp=0", out_result, out_store_data, out_dest); end
        checks++; if ({out_zero, in_ready} !== 2'b11) begin errors++;
            $display("FAIL reset_zero_ready got=%b exp=11", {out_zero, in_ready}); end
        $display("reset: ready=%b zero=%b", in_ready, out_zero);
    endtask

    task automatic test_add_fwd();
        int lat, bc;
        set_plain(4'b0010, 32'd1000, 32'd3);
        fwd_rs = 2'b01; fwd_mem_data = 32'd5; reg_dst = 1'b0; rt_addr = 5'd13;
        issue(lat, bc);
        checks++; if (lat !== 1 || out_result !== 32'd8 || out_zero !== 1'b0) begin errors++;
            $display("FAIL add_fwd lat=%0d res=%0d zero=%b exp lat=1 res=8 zero=0", lat, out_result, out_zero); end
        checks++; if (out_dest !== 5'd13 || out_store_data !== 32'd3) begin errors++;
            $display("FAIL add_fwd_dest dest=%0d sd=%0d exp 13/3", out_dest, out_store_data); end
        $display("add_fwd: res=%0d dest=%0d lat=%0d", out_result, out_dest, lat);
    endtask

    task automatic test_directed();
        logic [3:0]      ops [10] = '{4'b0001, 4'b0110, 4'b1111, 4'b0100, 4'b0100,
                                      4'b1000, 4'b1001, 4'b1000, 4'b1001, 4'b0000};
        logic [XLEN-1:0] as  [10] = '{32'hFFFF_FFFF, 9, 123, 7, 32'h1_0000, 100, 100, 5, 5, 32'h0F0F_0000};
        logic [XLEN-1:0] bs  [10] = '{1, 9, 456, 6, 32'h1_0000, 7, 7, 0, 0, 32'h0000_00FF};
        logic [XLEN-1:0] exs [10] = '{1, 0, 0, 42, 0, 14, 2, 32'hFFFF_FFFF, 5, 32'hF0F0_FF00};
        int lat, bc, exp_lat;
        for (int i = 0; i < 10; i++) begin
            set_plain(ops[i], as[i], bs[i]);
            issue(lat, bc);
            exp_lat = m_multi(ops[i]) ? XLEN + 1 : 1;
            checks++; if (out_result !== exs[i] || out_zero !== (exs[i] == 0)) begin errors++;
                $display("FAIL directed_%0d op=%b res=%h zero=%b exp res=%h", i, ops[i], out_result, out_zero, exs[i]); end
            checks++; if (lat !== exp_lat || out_multicycle !== m_multi(ops[i]) ||
                          bc !== (m_multi(ops[i]) ? XLEN : 0)) begin errors++;
                $display("FAIL directed_timing_%0d lat=%0d busy=%0d mc=%b exp lat=%0d", i, lat, bc, out_multicycle, exp_lat); end
            $display("directed %0d: op=%b res=%h lat=%0d", i, ops[i], out_result, lat);
        end
    endtask

    task automatic test_flush();
        int pulses = 0;
        logic [XLEN-1:0] held;
        set_plain(4'b0100, 32'd11, 32'd13);
        in_valid = 1'b1; @(posedge clk); #1; in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy got=%b exp=1", busy); end
        flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
        checks++; if ({busy, in_ready, out_valid} !== 3'b010) begin errors++;
            $display("FAIL flush_idle busy/ready/valid got=%b exp=010", {busy, in_ready, out_valid}); end
        repeat (XLEN + 4) begin @(posedge clk); #1; if (out_valid) pulses++; end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL flush_no_pulse got=%0d exp=0", pulses); end
        held = out_result;
        set_plain(4'b0100, 32'd3, 32'd3);
        in_valid = 1'b1; flush = 1'b1; @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++;
            $display("FAIL flush_same_cycle_mul busy=%b valid=%b exp 0/0", busy, out_valid); end
        set_plain(4'b0010, 32'd40, 32'd2);
        in_valid = 1'b1; flush = 1'b1; @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_result !== held) begin errors++;
            $display("FAIL flush_same_cycle_add valid=%b res=%h exp 0/%h", out_valid, out_result, held); end
        $display("flush: pulses=%0d ready=%b", pulses, in_ready);
    endtask

    task automatic test_back_to_back();
        int n = 1;
        set_plain(4'b0100, 32'd3, 32'd5);
        in_valid = 1'b1; @(posedge clk); #1;
        set_plain(4'b0010, 32'd20, 32'd22);
        while (!out_valid && n < 4 * XLEN) begin @(posedge clk); #1; n++; end
        checks++; if (n !== XLEN + 1 || out_result !== 32'd15 || out_multicycle !== 1'b1 || in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_mul n=%0d res=%0d mc=%b ready=%b exp %0d/15/1/1",
                               n, out_result, out_multicycle, in_ready, XLEN + 1); end
        @(posedge clk); #1; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_result !== 32'd42 || out_multicycle !== 1'b0) begin errors++;
            $display("FAIL b2b_add valid=%b res=%0d mc=%b exp 1/42/0", out_valid, out_result, out_multicycle); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || out_result !== 32'd42) begin errors++;
            $display("FAIL b2b_pulse valid=%b res=%0d exp 0/42", out_valid, out_result); end
        $display("back_to_back: mul_lat=%0d add_res=%0d", n, out_result);
    endtask

    task automatic test_rst_mid_div();
        set_plain(4'b1000, 32'd1000, 32'd3);
        in_valid = 1'b1; @(posedge clk); #1; in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        checks++; if ({out_valid, out_multicycle, busy, out_result, out_store_data, out_dest} !== '0 ||
                      {out_zero, in_ready} !== 2'b11) begin errors++;
            $display("FAIL rst_mid_div valid=%b mc=%b busy=%b res=%h sd=%h dest=%h zero=%b ready=%b",
                     out_valid, out_multicycle, busy, out_result, out_store_data, out_dest, out_zero, in_ready); end
        $display("rst_mid_div: busy=%b ready=%b", busy, in_ready);
    endtask

    task automatic test_random();
        logic [3:0] op_pool [12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0011, 4'b0111,
                                     4'b0100, 4'b1000, 4'b1001, 4'b1010, 4'b0101, 4'b1111};
        logic [XLEN-1:0] a, w, b, exp_res;
        logic [REG_AW-1:0] exp_dest;
        int lat, bc, exp_lat;
        for (int i = 0; i < 30; i++) begin
            alu_op = op_pool[$urandom_range(0, 11)];
            alu_src = 1'($urandom); reg_dst = 1'($urandom);
            rs_data = $urandom; rt_data = $urandom; imm = $urandom;
            fwd_mem_data = $urandom; fwd_wb_data = $urandom;
            if ($urandom_range(0, 2) == 0) begin rt_data = $urandom_range(0, 20); imm = $urandom_range(0, 20); end
            fwd_rs = 2'($urandom); fwd_rt = 2'($urandom);
            rd_addr = 5'($urandom); rt_addr = 5'($urandom);
            a = m_sel(fwd_rs, rs_data, fwd_mem_data, fwd_wb_data);
            w = m_sel(fwd_rt, rt_data, fwd_mem_data, fwd_wb_data);
            b = alu_src ? imm : w;
            exp_res = m_alu(alu_op, a, b);
            exp_dest = reg_dst ? rd_addr : rt_addr;
            exp_lat = m_multi(alu_op) ? XLEN + 1 : 1;
            issue(lat, bc);
            checks++; if (out_result !== exp_res || out_zero !== (exp_res == 0) || lat !== exp_lat) begin errors++;
                $display("FAIL rand_%0d op=%b a=%h b=%h res=%h lat=%0d exp res=%h lat=%0d",
                         i, alu_op, a, b, out_result, lat, exp_res, exp_lat); end
            checks++; if (out_dest !== exp_dest || out_store_data !== w || out_multicycle !== m_multi(alu_op)) begin
                errors++; $display("FAIL rand_side_%0d dest=%0d sd=%h mc=%b exp %0d/%h/%b",
                                   i, out_dest, out_store_data, out_multicycle, exp_dest, w, m_multi(alu_op)); end
            $display("rand %0d: op=%b a=%h b=%h res=%h lat=%0d", i, alu_op, a, b, out_result, lat);
        end
    endtask

    initial begin
        test_reset();
        test_add_fwd();
        test_directed();
        test_flush();
        test_back_to_back();
        test_rst_mid_div();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
